load_align_unit: RTL and testbench

Parametrised, multi-cycle load-data unit between the M-stage load request and the data-memory read port. It issues word-aligned memory reads, automatically splits a halfword or word load that crosses a DW-bit word boundary into two consecutive bus beats, then selects, aligns and zero- or sign-extends the addressed bytes into a DW-bit result for W-stage write-back. Byte lanes are little-endian: offset 0 is bits [7:0].

---
 rtl/load_align_unit_if.sv | 31 +++
 rtl/load_align_unit.sv | 127 ++++++++++++
 tb/tb_load_align_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_if.sv
// load_align_unit_if: bundles the load request, memory read port and result
// signals of load_align_unit.
//   ld_valid/ld_ready/ld_addr/ld_op : load request from M-stage
//   mem_req/mem_addr/mem_ack/mem_rdata : word-aligned data-memory read port
//   res_valid/res_data : extended result strobe toward W-stage
// slave  = the load unit itself, master = requester + memory model.
interface load_align_unit_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [2:0]    ld_op;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          res_valid;
  logic [DW-1:0] res_data;

  modport slave (
    input  ld_valid, ld_addr, ld_op, mem_ack, mem_rdata,
    output ld_ready, mem_req, mem_addr, res_valid, res_data
  );

  modport master (
    output ld_valid, ld_addr, ld_op, mem_ack, mem_rdata,
    input  ld_ready, mem_req, mem_addr, res_valid, res_data
  );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: multi-cycle load-data unit. Issues word-aligned reads,
// splits boundary-crossing half/word loads into two beats, then selects,
// aligns and zero/sign-extends the addressed bytes (little-endian lanes).
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : load_align_unit_if.slave (request, memory port, result)
module load_align_unit #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  load_align_unit_if.slave  bus
);
  localparam int NB = DW / 8;         // bytes per bus word
  localparam int OW = $clog2(NB);     // byte-offset width
  localparam int SW = OW + 2;         // wide enough for off + size

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_DONE} state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;      // aligned address of first beat
  logic [AW-1:0] r_mem_addr;
  logic [2:0]    r_op;
  logic [OW-1:0] r_off;
  logic          r_split;
  logic [DW-1:0] r_lo;
  logic [DW-1:0] r_hi;
  logic          r_ld_ready;
  logic          r_mem_req;
  logic          r_res_valid;

  logic [OW-1:0] w_off;
  logic [SW-1:0] w_size;
  logic          w_split;
  logic [AW-1:0] w_aligned;
  logic [DW-1:0] w_win;
  logic [DW-1:0] w_res;

  // Request decode, used only on the accept edge.
  always_comb begin
    w_off = bus.ld_addr[OW-1:0];
    case (bus.ld_op)
      3'd1, 3'd2: w_size = SW'(1);
      3'd3, 3'd4: w_size = SW'(2);
      default:    w_size = SW'(NB);
    endcase
    w_split   = ({2'b00, w_off} + w_size) > SW'(NB);
    w_aligned = {bus.ld_addr[AW-1:OW], {OW{1'b0}}};
  end

  // Byte window starting at the load offset; hi_buf is zero for unsplit loads.
  always_comb begin
    w_win = DW'({r_hi, r_lo} >> {r_off, 3'b000});
    case (r_op)
      3'd1:    w_res = {{(DW-8){1'b0}},      w_win[7:0]};
      3'd2:    w_res = {{(DW-8){w_win[7]}},  w_win[7:0]};
      3'd3:    w_res = {{(DW-16){1'b0}},     w_win[15:0]};
      3'd4:    w_res = {{(DW-16){w_win[15]}}, w_win[15:0]};
      default: w_res = w_win;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_op        <= '0;
      r_off       <= '0;
      r_split     <= 1'b0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_ld_ready  <= 1'b1;
      r_mem_req   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ld_valid) begin
            r_addr     <= w_aligned;
            r_mem_addr <= w_aligned;
            r_op       <= bus.ld_op;
            r_off      <= w_off;
            r_split    <= w_split;
            r_hi       <= '0;
            r_ld_ready <= 1'b0;
            r_mem_req  <= 1'b1;
            r_state    <= S_BEAT0;
          end
        end
        S_BEAT0: begin
          if (bus.mem_ack) begin
            r_lo <= bus.mem_rdata;
            if (r_split) begin
              r_mem_addr <= r_addr + AW'(NB);   // wraps modulo 2^AW
              r_state    <= S_BEAT1;
            end else begin
              r_mem_req   <= 1'b0;
              r_res_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_BEAT1: begin
          if (bus.mem_ack) begin
            r_hi        <= bus.mem_rdata;
            r_mem_req   <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        default: begin // S_DONE
          r_res_valid <= 1'b0;
          r_ld_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ld_ready  = r_ld_ready;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = w_res;
endmodule

// File: tb/tb_load_align_unit.sv
module tb_load_align_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_align_unit_if #(.DW(32), .AW(32)) ifc32 ();
  load_align_unit_if #(.DW(64), .AW(32)) ifc64 ();

  load_align_unit #(.DW(32), .AW(32)) u32 (.i_clk(clk), .i_rst(rst), .bus(ifc32));
  load_align_unit #(.DW(64), .AW(32)) u64 (.i_clk(clk), .i_rst(rst), .bus(ifc64));

  // index 0 = DW32 unit, 1 = DW64 unit
  logic        d_valid [2];
  logic [31:0] d_addr  [2];
  logic [2:0]  d_op    [2];
  logic        d_ack   [2];
  logic [63:0] d_rdata [2];
  logic        o_ready [2];
  logic        o_req   [2];
  logic        o_rv    [2];
  logic [31:0] o_maddr [2];
  logic [63:0] o_res   [2];

  assign ifc32.ld_valid  = d_valid[0];
  assign ifc32.ld_addr   = d_addr[0];
  assign ifc32.ld_op     = d_op[0];
  assign ifc32.mem_ack   = d_ack[0];
  assign ifc32.mem_rdata = d_rdata[0][31:0];
  assign ifc64.ld_valid  = d_valid[1];
  assign ifc64.ld_addr   = d_addr[1];
  assign ifc64.ld_op     = d_op[1];
  assign ifc64.mem_ack   = d_ack[1];
  assign ifc64.mem_rdata = d_rdata[1];

  assign o_ready[0] = ifc32.ld_ready;
  assign o_req[0]   = ifc32.mem_req;
  assign o_rv[0]    = ifc32.res_valid;
  assign o_maddr[0] = ifc32.mem_addr;
  assign o_res[0]   = {32'h0, ifc32.res_data};
  assign o_ready[1] = ifc64.ld_ready;
  assign o_req[1]   = ifc64.mem_req;
  assign o_rv[1]    = ifc64.res_valid;
  assign o_maddr[1] = ifc64.mem_addr;
  assign o_res[1]   = ifc64.res_data;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: lay out the fetched words as a byte array, pick the addressed
  // bytes in little-endian order, then extend.
  function automatic logic [63:0] model(input int nb, input int off, input int size,
                                        input logic [2:0] op, input logic [63:0] lo,
                                        input logic [63:0] hi, input bit split);
    logic [7:0]  b [16];
    logic [63:0] v;
    for (int i = 0; i < nb; i++) begin
      b[i]      = lo[8*i +: 8];
      b[nb + i] = split ? hi[8*i +: 8] : 8'h00;
    end
    v = '0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = b[off + i];
    if ((op == 3'd2 || op == 3'd4) && v[8*size-1])
      for (int i = 8*size; i < 64; i++) v[i] = 1'b1;
    if (nb == 4) v[63:32] = '0;
    return v;
  endfunction

  // One memory beat: w wait cycles (with ignored ld_valid noise), then ack.
  task automatic beat(input int k, input logic [31:0] exp_addr, input logic [63:0] data,
                      input int w, input string tag);
    for (int i = 0; i < w; i++) begin
      chk({tag, ".wait_req"}, 64'(o_req[k]), 64'd1);
      chk({tag, ".wait_addr"}, 64'(o_maddr[k]), 64'(exp_addr));
      d_valid[k] = 1'($urandom);
      d_addr[k]  = $urandom;
      @(negedge clk);
    end
    d_valid[k] = 1'b0;
    chk({tag, ".req"}, 64'(o_req[k]), 64'd1);
    chk({tag, ".addr"}, 64'(o_maddr[k]), 64'(exp_addr));
    d_ack[k]   = 1'b1;
    d_rdata[k] = data;
    @(negedge clk);
    d_ack[k]   = 1'b0;
    d_rdata[k] = {$urandom, $urandom};
  endtask

  task automatic run_load(input int k, input logic [31:0] addr, input logic [2:0] op,
                          input logic [63:0] lo, input logic [63:0] hi,
                          input int w0, input int w1, input bit use_fix,
                          input logic [63:0] fix, input string tag);
    int nb, off, size;
    bit split;
    logic [31:0] al;
    logic [63:0] exp;
    nb    = (k == 0) ? 4 : 8;
    size  = (op == 3'd1 || op == 3'd2) ? 1 : (op == 3'd3 || op == 3'd4) ? 2 : nb;
    off   = int'(addr) & (nb - 1);
    split = (off + size) > nb;
    al    = addr & ~32'(nb - 1);
    exp   = use_fix ? fix : model(nb, off, size, op, lo, hi, split);
    chk({tag, ".ready"}, 64'(o_ready[k]), 64'd1);
    d_valid[k] = 1'b1;
    d_addr[k]  = addr;
    d_op[k]    = op;
    @(negedge clk);
    d_valid[k] = 1'b0;
    beat(k, al, lo, w0, {tag, ".b0"});
    if (split) beat(k, al + 32'(nb), hi, w1, {tag, ".b1"});
    chk({tag, ".res_valid"}, 64'(o_rv[k]), 64'd1);
    chk({tag, ".res_data"}, o_res[k], exp);
    chk({tag, ".req_off"}, 64'(o_req[k]), 64'd0);
    @(negedge clk);
    chk({tag, ".rv_drop"}, 64'(o_rv[k]), 64'd0);
    chk({tag, ".ready_back"}, 64'(o_ready[k]), 64'd1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      d_valid[k] = 0; d_addr[k] = 0; d_op[k] = 0; d_ack[k] = 0; d_rdata[k] = 0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst.ready", 64'(o_ready[k]), 64'd1);
      chk("rst.req",   64'(o_req[k]),   64'd0);
      chk("rst.maddr", 64'(o_maddr[k]), 64'd0);
      chk("rst.rv",    64'(o_rv[k]),    64'd0);
      chk("rst.res",   o_res[k],        64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // ack with no request outstanding is ignored
    d_ack[0] = 1'b1; d_ack[1] = 1'b1;
    @(negedge clk);
    d_ack[0] = 1'b0; d_ack[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("idle_ack.req",   64'(o_req[k]),   64'd0);
      chk("idle_ack.ready", 64'(o_ready[k]), 64'd1);
      chk("idle_ack.rv",    64'(o_rv[k]),    64'd0);
    end

    // directed cases
    run_load(0, 32'h1003, 3'd2, 64'h80FF_1234, 64'h0, 0, 0, 1, 64'hFFFF_FF80, "lb_1003");
    run_load(0, 32'h2002, 3'd3, 64'hBEEF_0000, 64'h0, 0, 0, 1, 64'h0000_BEEF, "lhu_2002");
    run_load(0, 32'h2002, 3'd4, 64'hBEEF_0000, 64'h0, 0, 0, 1, 64'hFFFF_BEEF, "lh_2002");
    run_load(0, 32'h3003, 3'd4, 64'hAB00_0000, 64'h0000_00CD, 0, 0, 1, 64'hFFFF_CDAB, "lh_split");
    run_load(0, 32'h3001, 3'd4, 64'h00AB_CD00, 64'h0, 0, 0, 1, 64'hFFFF_ABCD, "lh_off1");
    run_load(1, 32'h8, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0, 2, 0, 1,
             64'h0123_4567_89AB_CDEF, "dw64_word_wait");
    run_load(0, 32'hFFFF_FFFE, 3'd0, 64'h4433_2211, 64'h8877_6655, 1, 1, 1,
             64'h6655_4433, "word_wrap");

    // reset during BEAT1 wait
    chk("rstmid.ready", 64'(o_ready[0]), 64'd1);
    d_valid[0] = 1'b1; d_addr[0] = 32'h3003; d_op[0] = 3'd4;
    @(negedge clk);
    d_valid[0] = 1'b0;
    d_ack[0] = 1'b1; d_rdata[0] = 64'hAB00_0000;
    @(negedge clk);
    d_ack[0] = 1'b0;
    chk("rstmid.b1_req",  64'(o_req[0]),   64'd1);
    chk("rstmid.b1_addr", 64'(o_maddr[0]), 64'h3004);
    d_ack[0] = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rstmid.req_drop", 64'(o_req[0]), 64'd0);
    chk("rstmid.rv",       64'(o_rv[0]),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    d_ack[0] = 1'b0;
    @(negedge clk);
    chk("rstmid.ready_after", 64'(o_ready[0]), 64'd1);
    chk("rstmid.rv_after",    64'(o_rv[0]),    64'd0);
    chk("rstmid.req_after",   64'(o_req[0]),   64'd0);
    run_load(0, 32'h4002, 3'd1, 64'h5566_7788, 64'h0, 0, 0, 1, 64'h0000_0066, "lbu_after_rst");

    // randomized loads on both widths
    for (int n = 0; n < 60; n++) begin
      int k;
      k = n & 1;
      run_load(k, $urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom},
               {$urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 2),
               0, 64'h0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
